// File: rtl/vram_addr_arbiter_pkg.sv
// VRAM address arbiter shared definitions: FSM state encoding, mux select
// polarity and the grant decision type.
// Latency: n/a (types and constants only). Backpressure: n/a.
package vram_addr_arbiter_pkg;

  // State encoding is fixed; other blocks decode these values directly.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN_ADDR = 3'd1,
    SCAN_DATA = 3'd2,
    CPU_ADDR  = 3'd3,
    CPU_DATA  = 3'd4
  } arb_state_t;

  // nSELA polarity on the quad 2-input mux bank: A = scanner, B = CPU.
  localparam logic MUX_SEL_SCAN = 1'b0;
  localparam logic MUX_SEL_CPU  = 1'b1;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_SCAN = 2'd1,
    GNT_CPU  = 2'd2
  } grant_t;

  // A new grant may only be taken from IDLE or at the end of a data phase.
  function automatic logic is_arb_point(input arb_state_t s);
    return (s == IDLE) || (s == SCAN_DATA) || (s == CPU_DATA);
  endfunction

endpackage

// File: rtl/vram_grant_select.sv
// Next-grant decision: fixed scanner priority, optional CPU starvation guard.
// Latency: combinational grant; run counter updates on the clock edge.
// Backpressure: none; requests are levels held by the requesters.
//
// Ports: clk/rst_n (run counter only), arb_en (FSM is at a grant point),
//        scan_req/cpu_req (request levels), grant (decision for this edge).
// Build option: CPU_STARVE_GUARD_EN enables the scanner run limit.
module vram_grant_select
  import vram_addr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_SCAN_RUN = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   arb_en,
  input  logic   scan_req,
  input  logic   cpu_req,
  output grant_t grant
);

  logic force_cpu;

`ifdef CPU_STARVE_GUARD_EN
  localparam int RUN_W = (MAX_SCAN_RUN < 1) ? 1 : $clog2(MAX_SCAN_RUN + 1);

  // Consecutive scanner grants taken while the CPU was waiting.
  logic [RUN_W-1:0] run_cnt;

  assign force_cpu = cpu_req && (run_cnt >= RUN_W'(MAX_SCAN_RUN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (!cpu_req) begin
      run_cnt <= '0;
    end else if (arb_en) begin
      if (grant == GNT_CPU) begin
        run_cnt <= '0;
      end else if (grant == GNT_SCAN && run_cnt < RUN_W'(MAX_SCAN_RUN)) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
    end
  end
`else
  // Pure fixed priority: the counter and its clock are not needed.
  logic unused_guard;
  assign force_cpu    = 1'b0;
  assign unused_guard = ^{clk, rst_n, arb_en, MAX_SCAN_RUN[0]};
`endif

  always_comb begin
    grant = GNT_NONE;
    if (scan_req && !force_cpu) begin
      grant = GNT_SCAN;
    end else if (cpu_req) begin
      grant = GNT_CPU;
    end
  end

endmodule

// File: rtl/vram_addr_arbiter.sv
// Time-slot arbiter sharing the VRAM address bus between scanner and CPU.
// Latency: request sampled at edge N -> ACK during cycle N+2; 2 cycles/access.
// Backpressure: requesters hold REQ until ACK; CPU sees nWAIT low while queued.
//
// Ports: CLK, nRESET (async, active low); SCAN_REQ, CPU_REQ, CPU_WE in;
//        SCAN_ACK, CPU_ACK, nWAIT, and mux/RAM controls nSELA, nG, nWE out.
// Build option: CPU_STARVE_GUARD_EN (see vram_grant_select).
module vram_addr_arbiter
  import vram_addr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_SCAN_RUN = 3
) (
  input  logic CLK,
  input  logic nRESET,
  input  logic SCAN_REQ,
  input  logic CPU_REQ,
  input  logic CPU_WE,
  output logic SCAN_ACK,
  output logic CPU_ACK,
  output logic nWAIT,
  output logic nSELA,
  output logic nG,
  output logic nWE
);

  arb_state_t state_q;
  arb_state_t state_d;
  grant_t     grant;
  logic       arb_en;
  logic       we_q;

  assign arb_en = is_arb_point(state_q);

  vram_grant_select #(
    .MAX_SCAN_RUN (MAX_SCAN_RUN)
  ) u_grant_select (
    .clk      (CLK),
    .rst_n    (nRESET),
    .arb_en   (arb_en),
    .scan_req (SCAN_REQ),
    .cpu_req  (CPU_REQ),
    .grant    (grant)
  );

  // Address phase always runs into its data phase; otherwise take the grant.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      SCAN_ADDR: state_d = SCAN_DATA;
      CPU_ADDR:  state_d = CPU_DATA;
      default: begin
        case (grant)
          GNT_SCAN: state_d = SCAN_ADDR;
          GNT_CPU:  state_d = CPU_ADDR;
          default:  state_d = IDLE;
        endcase
      end
    endcase
  end

  // All outputs are registered from the next state so they change cleanly
  // on the edge that enters each phase.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      nSELA    <= MUX_SEL_SCAN;
      nG       <= 1'b1;
      nWE      <= 1'b1;
      SCAN_ACK <= 1'b0;
      CPU_ACK  <= 1'b0;
      nWAIT    <= 1'b1;
    end else begin
      state_q  <= state_d;
      nG       <= (state_d == IDLE);
      SCAN_ACK <= (state_d == SCAN_DATA);
      CPU_ACK  <= (state_d == CPU_DATA);

      // Select only moves when an address phase starts, so it is stable
      // across the whole data phase and through the write strobe.
      if (state_d == SCAN_ADDR) begin
        nSELA <= MUX_SEL_SCAN;
      end else if (state_d == CPU_ADDR) begin
        nSELA <= MUX_SEL_CPU;
      end

      if (state_d == CPU_ADDR) begin
        we_q <= CPU_WE;
      end

      // we_q was captured one edge earlier, on entry to CPU_ADDR.
      nWE <= !((state_d == CPU_DATA) && we_q);

      // Released on the ACK cycle; unchanged while the CPU's own address
      // phase runs (high if granted at once, low if it had been queued).
      if (state_d == CPU_DATA) begin
        nWAIT <= 1'b1;
      end else if (state_d != CPU_ADDR) begin
        nWAIT <= !CPU_REQ;
      end
    end
  end

endmodule

// File: tb/tb_vram_addr_arbiter.sv
`timescale 1ns/1ps
module tb_vram_addr_arbiter;

  localparam int MAX_RUN = 3;
`ifdef CPU_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRESET, SCAN_REQ, CPU_REQ, CPU_WE;
  logic SCAN_ACK, CPU_ACK, nWAIT, nSELA, nG, nWE;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  vram_addr_arbiter #(.MAX_SCAN_RUN(MAX_RUN)) dut (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .SCAN_REQ (SCAN_REQ),
    .CPU_REQ  (CPU_REQ),
    .CPU_WE   (CPU_WE),
    .SCAN_ACK (SCAN_ACK),
    .CPU_ACK  (CPU_ACK),
    .nWAIT    (nWAIT),
    .nSELA    (nSELA),
    .nG       (nG),
    .nWE      (nWE)
  );

  // Reference model: who owns the bus and which cycle (1 = address,
  // 2 = data) of its two-cycle access it is in.
  int owner;      // 0 none, 1 scanner, 2 cpu
  int acc_cycle;
  bit m_sel, m_we, m_wait;
  int m_run;

  task automatic model_reset();
    owner = 0; acc_cycle = 0; m_sel = 1'b0; m_we = 1'b0; m_wait = 1'b1; m_run = 0;
  endtask

  task automatic model_edge();
    bit s, c, cpu_turn;
    s = SCAN_REQ;
    c = CPU_REQ;
    if (owner != 0 && acc_cycle == 1) begin
      acc_cycle = 2;
      m_wait = (owner == 2) ? 1'b1 : !c;
    end else begin
      cpu_turn = GUARD && c && (m_run >= MAX_RUN);
      if (s && !cpu_turn) begin
        owner = 1; acc_cycle = 1; m_sel = 1'b0; m_wait = !c;
        m_run = m_run + 1;
      end else if (c) begin
        owner = 2; acc_cycle = 1; m_sel = 1'b1; m_we = CPU_WE; m_run = 0;
      end else begin
        owner = 0; acc_cycle = 0; m_wait = 1'b1;
      end
    end
    if (!c) m_run = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_nG"},   nG,       owner == 0);
    chk({tag, "_nSELA"}, nSELA,   m_sel);
    chk({tag, "_nWE"},  nWE,      !(owner == 2 && acc_cycle == 2 && m_we));
    chk({tag, "_sack"}, SCAN_ACK, owner == 1 && acc_cycle == 2);
    chk({tag, "_cack"}, CPU_ACK,  owner == 2 && acc_cycle == 2);
    chk({tag, "_nWAIT"}, nWAIT,   m_wait);
  endtask

  // One clock: model follows the edge, outputs are checked on the falling edge.
  task automatic step(input string tag);
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_model(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int first_cpu, scans_before, cpu_acks;

    // Reset held with both requests up.
    nRESET = 1'b0; SCAN_REQ = 1'b1; CPU_REQ = 1'b1; CPU_WE = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("rst_nG", nG, 1'b1);
    chk("rst_nSELA", nSELA, 1'b0);
    chk("rst_nWE", nWE, 1'b1);
    chk("rst_nWAIT", nWAIT, 1'b1);
    chk("rst_sack", SCAN_ACK, 1'b0);
    chk("rst_cack", CPU_ACK, 1'b0);
    nRESET = 1'b1;
    step("rel");
    chk("rel_scan_first_sel", nSELA, 1'b0);
    chk("rel_scan_first_g", nG, 1'b0);
    repeat (6) begin
      if (SCAN_ACK) SCAN_REQ = 1'b0;
      if (CPU_ACK) CPU_REQ = 1'b0;
      step("rel_drain");
    end

    // Lone CPU write; WE changes after grant and must not matter.
    CPU_REQ = 1'b1; CPU_WE = 1'b1;
    step("wr1");
    chk("wr_addr_sel", nSELA, 1'b1);
    chk("wr_addr_g", nG, 1'b0);
    chk("wr_addr_wait", nWAIT, 1'b1);
    CPU_WE = 1'b0;
    step("wr2");
    chk("wr_data_ack", CPU_ACK, 1'b1);
    chk("wr_data_nwe", nWE, 1'b0);
    chk("wr_data_wait", nWAIT, 1'b1);
    CPU_REQ = 1'b0;
    step("wr3");
    chk("wr_idle_g", nG, 1'b1);

    // Contention from IDLE: scanner first, CPU right behind.
    SCAN_REQ = 1'b1; CPU_REQ = 1'b1; CPU_WE = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step("cont");
      chk("cont_sack", SCAN_ACK, i == 2);
      chk("cont_cack", CPU_ACK, i == 4);
      chk("cont_nwait", nWAIT, i >= 4);
      if (SCAN_ACK) SCAN_REQ = 1'b0;
      if (CPU_ACK) CPU_REQ = 1'b0;
    end
    step("cont_idle");

    // Both requests held continuously.
    SCAN_REQ = 1'b1; CPU_REQ = 1'b1;
    first_cpu = 0; scans_before = 0; cpu_acks = 0;
    for (int i = 1; i <= 40; i++) begin
      step("starve");
      if (CPU_ACK) begin
        cpu_acks++;
        if (first_cpu == 0) first_cpu = i;
      end
      if (SCAN_ACK && first_cpu == 0) scans_before++;
      if (GUARD && i == 10) chk("starve_scan_resume", SCAN_ACK, 1'b1);
    end
    if (GUARD) begin
      chk("starve_first_cpu", first_cpu, 8);
      chk("starve_scans_before", scans_before, MAX_RUN);
    end else begin
      chk("starve_no_cpu_ack", cpu_acks, 0);
    end
    SCAN_REQ = 1'b0; CPU_REQ = 1'b0;
    repeat (3) step("starve_drain");

    // Reset during the data phase of a CPU write.
    CPU_REQ = 1'b1; CPU_WE = 1'b1;
    step("mid1");
    step("mid2");
    chk("mid_nwe_low", nWE, 1'b0);
    #2 nRESET = 1'b0;
    #1;
    chk("mid_nwe", nWE, 1'b1);
    chk("mid_cack", CPU_ACK, 1'b0);
    chk("mid_nG", nG, 1'b1);
    chk("mid_nSELA", nSELA, 1'b0);
    model_reset();
    CPU_REQ = 1'b0;
    @(negedge CLK);
    nRESET = 1'b1;
    step("mid_rel");
    chk("mid_idle", nG, 1'b1);

    // A scanner access, then the bus parks for 10 idle cycles.
    SCAN_REQ = 1'b1;
    step("park_a");
    step("park_b");
    SCAN_REQ = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step("park");
      chk("park_nG", nG, 1'b1);
      chk("park_nWE", nWE, 1'b1);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if (SCAN_REQ) begin
        if (SCAN_ACK && $urandom_range(3) != 0) SCAN_REQ = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        SCAN_REQ = 1'b1;
      end
      if (CPU_REQ) begin
        if (CPU_ACK && $urandom_range(3) != 0) CPU_REQ = 1'b0;
      end else if ($urandom_range(2) == 0) begin
        CPU_REQ = 1'b1;
        CPU_WE  = 1'($urandom_range(1));
      end
      if ($urandom_range(7) == 0) CPU_WE = ~CPU_WE;
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
